// File: rtl/lcd_nibble_writer.sv
// HD44780-style 4-bit write engine: strobes one byte as two nibbles (or one), then waits out the LCD execution time.
// Acceptance-to-done latency = strobe phases + nibble gap + execution wait; in_ready only while idle.
module lcd_nibble_writer #(
  parameter int T_SETUP     = 4,
  parameter int T_EPW       = 25,
  parameter int T_HOLD      = 4,
  parameter int T_NIB_GAP   = 100,
  parameter int T_EXEC      = 4000,
  parameter int T_EXEC_LONG = 152000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  input  logic       in_nibble_only,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_db,
  output logic       done
);

  localparam int CW = $clog2(T_EXEC_LONG + 1);
  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_EPW   = CW'(T_EPW - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_GAP   = CW'(T_NIB_GAP - 1);
  localparam logic [CW-1:0] C_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] C_LONG  = CW'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, GAP, EXEC} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [7:0]    data_q;
  logic          nib_q;
  logic          lower_q;
  logic          accept;
  logic          load_lo;
  logic          exec_done;
  logic          long_cmd;

  // Clear-display (0x01) and return-home (0x02/0x03) need the long execution wait
  assign long_cmd = !lcd_rs && !nib_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
  assign lcd_rw   = 1'b0;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    accept    = 1'b0;
    load_lo   = 1'b0;
    exec_done = 1'b0;
    if (state_q != IDLE && cnt_q != '0) begin
      cnt_n = cnt_q - CW'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            accept  = 1'b1;
            state_n = SETUP;
            cnt_n   = C_SETUP;
          end
        end
        SETUP: begin
          state_n = EHIGH;
          cnt_n   = C_EPW;
        end
        EHIGH: begin
          state_n = HOLD;
          cnt_n   = C_HOLD;
        end
        HOLD: begin
          if (!nib_q && !lower_q) begin
            state_n = GAP;
            cnt_n   = C_GAP;
          end else begin
            state_n = EXEC;
            cnt_n   = long_cmd ? C_LONG : C_EXEC;
          end
        end
        GAP: begin
          state_n = SETUP;
          cnt_n   = C_SETUP;
          load_lo = 1'b1;
        end
        EXEC: begin
          state_n   = IDLE;
          cnt_n     = '0;
          exec_done = 1'b1;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      in_ready <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_db   <= 4'h0;
      done     <= 1'b0;
      data_q   <= 8'h00;
      nib_q    <= 1'b0;
      lower_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      in_ready <= (state_n == IDLE);
      lcd_e    <= (state_n == EHIGH);
      done     <= exec_done;
      if (accept) begin
        lcd_rs  <= in_rs;
        lcd_db  <= in_data[7:4];
        data_q  <= in_data;
        nib_q   <= in_nibble_only;
        lower_q <= 1'b0;
      end else if (load_lo) begin
        lcd_db  <= data_q[3:0];
        lower_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Scoreboard bench: issued requests queue expected E pulses and done events; a negedge monitor checks them.
module tb_lcd_nibble_writer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_nibble_only = 1'b0;
  logic       lcd_rs, lcd_rw, lcd_e, done;
  logic [3:0] lcd_db;

  lcd_nibble_writer #(
    .T_SETUP(2), .T_EPW(3), .T_HOLD(2), .T_NIB_GAP(5), .T_EXEC(10), .T_EXEC_LONG(50)
  ) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
    .in_data(in_data), .in_nibble_only(in_nibble_only), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_db(lcd_db), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       kind;   // 0 = E pulse, 1 = done
    int         cyc;
    logic       rs;
    logic [3:0] db;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Monitor
  bit         in_pulse = 0;
  int         p_start, p_w;
  logic       p_rs, p_stable;
  logic [3:0] p_db;
  exp_t       m_e;

  always @(negedge clk) begin
    if (!nrst) begin
      in_pulse = 0;
    end else begin
      checks++;
      if (busy && in_ready && !done) begin
        errors++;
        $display("FAIL ready_busy: in_ready=1 at cycle %0d while a request is in flight", cyc);
      end
      if (lcd_e && !in_pulse) begin
        in_pulse = 1; p_start = cyc; p_w = 1; p_rs = lcd_rs; p_db = lcd_db; p_stable = 1;
      end else if (lcd_e) begin
        p_w++;
        if (lcd_rs !== p_rs || lcd_db !== p_db) p_stable = 0;
      end else if (in_pulse) begin
        in_pulse = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: E pulse at cycle %0d with nothing expected", p_start);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.kind !== 1'b0 || p_start != m_e.cyc || p_w != 3 || p_rs !== m_e.rs ||
              p_db !== m_e.db || !p_stable)
          begin
            errors++;
            $display("FAIL pulse: got start=%0d w=%0d rs=%0b db=%h stable=%0b, want kind=%0b start=%0d w=3 rs=%0b db=%h",
                     p_start, p_w, p_rs, p_db, p_stable, m_e.kind, m_e.cyc, m_e.rs, m_e.db);
          end
        end
      end
      if (done) begin
        checks++;
        busy = 0;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done at cycle %0d with nothing expected", cyc);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.kind !== 1'b1 || cyc != m_e.cyc || lcd_rs !== m_e.rs || lcd_db !== m_e.db ||
              in_ready !== 1'b1 || lcd_e !== 1'b0 || lcd_rw !== 1'b0)
          begin
            errors++;
            $display("FAIL done: got cyc=%0d rs=%0b db=%h rdy=%0b e=%0b rw=%0b, want kind=%0b cyc=%0d rs=%0b db=%h rdy=1 e=0 rw=0",
                     cyc, lcd_rs, lcd_db, in_ready, lcd_e, lcd_rw, m_e.kind, m_e.cyc, m_e.rs, m_e.db);
          end
        end
      end
    end
  end

  // Stimulus
  task automatic issue(input logic rs, input logic [7:0] d, input logic nib, input int lat,
                       input bit hold, input bit corrupt, output int acc);
    int n;
    acc = -1;
    @(negedge clk);
    in_rs = rs; in_data = d; in_nibble_only = nib; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never rose for data %h", d);
      in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    exp_q.push_back('{kind: 1'b0, cyc: acc + 2, rs: rs, db: d[7:4]});
    if (!nib) exp_q.push_back('{kind: 1'b0, cyc: acc + 14, rs: rs, db: d[3:0]});
    exp_q.push_back('{kind: 1'b1, cyc: acc + lat, rs: rs, db: nib ? d[7:4] : d[3:0]});
    @(posedge clk);
    busy = 1;
    #1;
    if (corrupt) in_data = 8'hFF;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d expected events never seen", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_rs_db", {27'd0, lcd_rs, lcd_db}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    issue(1'b1, 8'h41, 1'b0, 29, 0, 0, acc); wait_idle();   // data byte
    issue(1'b0, 8'h01, 1'b0, 69, 0, 0, acc); wait_idle();   // clear display
    issue(1'b0, 8'h28, 1'b0, 29, 0, 0, acc); wait_idle();   // function set
    issue(1'b0, 8'h03, 1'b0, 69, 0, 0, acc); wait_idle();   // return home, top of range
    issue(1'b0, 8'h04, 1'b0, 29, 0, 0, acc); wait_idle();   // just above range
    issue(1'b0, 8'h00, 1'b0, 29, 0, 0, acc); wait_idle();   // just below range
    issue(1'b1, 8'h01, 1'b0, 29, 0, 0, acc); wait_idle();   // data 0x01 is not a clear
    issue(1'b0, 8'h30, 1'b1, 17, 0, 0, acc); wait_idle();   // init nibble
    issue(1'b0, 8'h01, 1'b1, 17, 0, 0, acc); wait_idle();   // nibble-only never long
    issue(1'b1, 8'h5A, 1'b0, 29, 0, 1, acc); wait_idle();   // inputs altered after accept

    issue(1'b1, 8'h48, 1'b0, 29, 1, 0, acc);
    issue(1'b1, 8'h49, 1'b0, 29, 1, 0, acc);
    issue(1'b0, 8'h02, 1'b0, 69, 0, 0, acc);
    wait_idle();

    // Reset in the middle of the upper-nibble E pulse
    issue(1'b1, 8'h41, 1'b0, 29, 0, 0, acc);
    repeat (3) @(posedge clk);
    #2;
    chk("e_before_rst", {31'd0, lcd_e}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("e_async_rst", {31'd0, lcd_e}, 32'd0);
    chk("ready_in_rst", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    busy = 0;
    @(negedge clk);
    chk("rst_mid_outputs", {26'd0, done, lcd_rs, lcd_db}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_mid_rst", {31'd0, in_ready}, 32'd1);
    repeat (30) @(negedge clk);   // any stray done would be flagged by the monitor
    issue(1'b1, 8'h41, 1'b0, 29, 0, 0, acc); wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_writer.md
LCD_NIBBLE_WRITER -- requirements
Module: lcd_nibble_writer

Interface
REQ-001 Parameter T_SETUP, default 4: cycles with RS/DB valid and E low before E rises (40 ns at 100 MHz).
REQ-002 Parameter T_EPW, default 25: cycles E is high (250 ns).
REQ-003 Parameter T_HOLD, default 4: cycles RS/DB are held with E low after E falls.
REQ-004 Parameter T_NIB_GAP, default 100: idle cycles between the upper- and lower-nibble strobes (1 us).
REQ-005 Parameter T_EXEC, default 4000: execution wait after a normal command or data write (40 us).
REQ-006 Parameter T_EXEC_LONG, default 152000: execution wait after clear-display or return-home (1.52 ms).
REQ-007 Port clk, input, 1: system clock, 100 MHz.
REQ-008 Port nrst, input, 1: asynchronous, active-low reset.
REQ-009 Port in_valid, input, 1: upstream request valid.
REQ-010 Port in_ready, output, 1: block can accept a request.
REQ-011 Port in_rs, input, 1: 0 = instruction, 1 = data register.
REQ-012 Port in_data, input, 8: byte to send.
REQ-013 Port in_nibble_only, input, 1: send only in_data[7:4], as a single strobe (init 0x3/0x2 writes).
REQ-014 Port lcd_rs, output, 1: LCD register select.
REQ-015 Port lcd_rw, output, 1: LCD read/write, constant 0 (write-only block).
REQ-016 Port lcd_e, output, 1: LCD enable strobe.
REQ-017 Port lcd_db, output, 4: LCD DB7..DB4.
REQ-018 Port done, output, 1: one-cycle pulse when a request's execution wait completes.

Function
REQ-019 The state machine SHALL have states IDLE, SETUP, EHIGH, HOLD, GAP and EXEC, with a single down-counter sized for T_EXEC_LONG.
REQ-020 The SETUP, EHIGH, HOLD, GAP and EXEC phases SHALL each last exactly their parameter's number of cycles.
REQ-021 in_ready SHALL be 1 only in IDLE.
REQ-022 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
  - On acceptance, in_rs, in_data and in_nibble_only are latched.
  - Input changes after acceptance are ignored.
REQ-023 On the acceptance edge, the block SHALL enter SETUP and drive lcd_rs = latched rs and lcd_db = data[7:4], with lcd_e = 0.
REQ-024 SETUP SHALL be followed by EHIGH (lcd_e = 1), then HOLD (lcd_e = 0), with lcd_rs and lcd_db unchanged throughout.
REQ-025 After the upper-nibble HOLD, with a second nibble pending, the block SHALL go GAP -> SETUP and drive lcd_db = data[3:0], then repeat EHIGH and HOLD.
REQ-026 After the final HOLD, the block SHALL enter EXEC.
REQ-027 The EXEC length SHALL be T_EXEC_LONG when rs = 0, nibble_only = 0 and data is in 0x01..0x03; otherwise it SHALL be T_EXEC.
REQ-028 On the last EXEC cycle's edge, the block SHALL return to IDLE; done SHALL be 1 for that one IDLE cycle, and in_ready SHALL be 1 in the same cycle.
REQ-029 Latency from the acceptance edge to done SHALL be:
  - full byte: 2*(T_SETUP+T_EPW+T_HOLD)+T_NIB_GAP+EXEC cycles;
  - nibble_only: T_SETUP+T_EPW+T_HOLD+EXEC cycles.
REQ-030 A back-to-back request held valid during the done cycle SHALL be accepted on that cycle's edge, with no extra idle cycle.
REQ-031 lcd_rs and lcd_db SHALL hold their last driven values in GAP, EXEC and IDLE, and SHALL change only on entry to SETUP.
REQ-032 lcd_e SHALL be 1 only in EHIGH; all LCD outputs SHALL be registered and glitch-free.
REQ-033 lcd_rw SHALL be 0 at all times, including during reset.

Reset
REQ-034 While nrst = 0, the block SHALL hold: state IDLE, counter 0, lcd_e 0, lcd_rs 0, lcd_db 0000, done 0 and in_ready 0.
REQ-035 in_ready SHALL rise on the first clk edge after nrst deasserts.
REQ-036 Reset asserted mid-transfer, including during EHIGH, SHALL force lcd_e low immediately and drop the request without a done pulse.

Verification (sim parameters T_SETUP=2, T_EPW=3, T_HOLD=2, T_NIB_GAP=5, T_EXEC=10, T_EXEC_LONG=50)
REQ-037 Data byte: rs=1, data=0x41 accepted at edge 0 -> lcd_e high in cycles 2-4 with db=0100 and in cycles 14-16 with db=0001, lcd_rs=1 throughout, done at cycle 29.
REQ-038 Clear display: rs=0, data=0x01 -> EXEC lasts 50 cycles, done at cycle 69; repeat with data=0x28 -> done at cycle 29.
REQ-039 Nibble-only: rs=0, data=0x30, nibble_only=1 -> exactly one E pulse with db=0011, no GAP, done at cycle 17.
REQ-040 Back-to-back: in_valid held high for 3 requests -> each accepted in its done cycle, and in_ready is never 1 outside IDLE.
REQ-041 Reset during EHIGH of the upper nibble -> lcd_e=0 asynchronously, no done pulse, in_ready=1 on the first edge after release, and the next request behaves as in REQ-037.
REQ-042 Input change after acceptance: in_data altered to 0xFF on edge 1 -> the nibbles driven are still those of the latched byte.
